// File: rtl/seq_scan_if.sv
// rtl/seq_scan_if.sv - host-side bundle for the serial pattern scan controller
interface seq_scan_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8,
    parameter int BUD_W = 16
);
    logic             start;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic [BUD_W-1:0] cfg_budget;
    logic             xin;
    logic             xin_valid;
    logic             abort;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             done;
    logic             result_hit;
    logic             result_timeout;
    logic             cfg_err;

    modport master (
        output start, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_budget,
        output xin, xin_valid, abort,
        input  busy, match, match_cnt, done, result_hit, result_timeout, cfg_err
    );

    modport slave (
        input  start, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_budget,
        input  xin, xin_valid, abort,
        output busy, match, match_cnt, done, result_hit, result_timeout, cfg_err
    );
endinterface

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - session engine: programmable serial pattern detect, count, terminate
module seq_scan_ctrl #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8,
    parameter int BUD_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    seq_scan_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;

    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;
    logic [CNT_W-1:0] r_target;
    logic [BUD_W-1:0] r_budget;
    logic [PAT_W-2:0] r_hist;
    logic [LEN_W-1:0] r_seen;
    logic [BUD_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_match_cnt;
    logic             r_hit;
    logic             r_timeout;
    logic             r_cfg_err;
    logic             r_match;

    logic [PAT_W-1:0] w_shift;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W:0]   w_seen_inc;
    logic [LEN_W-1:0] w_seen_sat;
    logic             w_window_full;
    logic             w_accept;
    logic             w_match;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [BUD_W-1:0] w_bit_inc;
    logic             w_hit_end;
    logic             w_budget_end;
    logic             w_cfg_bad;

    // The newest bit lands in bit 0, so pattern bit [len-1] faces the oldest bit of the window.
    assign w_shift       = {r_hist, bus.xin};
    assign w_seen_inc    = {1'b0, r_seen} + 1'b1;
    assign w_window_full = (w_seen_inc >= {1'b0, r_len});
    assign w_seen_sat    = w_window_full ? r_len : w_seen_inc[LEN_W-1:0];
    assign w_accept      = (r_state == S_SCAN) && bus.xin_valid && !bus.abort;
    assign w_cnt_inc     = r_match_cnt + 1'b1;
    assign w_bit_inc     = r_bit_cnt + 1'b1;
    assign w_cfg_bad     = (bus.cfg_len == '0) || (int'(bus.cfg_len) > PAT_W) ||
                           (bus.cfg_target == '0);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_match      = w_window_full && (((w_shift ^ r_pat) & w_mask) == '0);
    assign w_hit_end    = w_match && (w_cnt_inc == r_target);
    assign w_budget_end = (r_budget != '0) && (w_bit_inc == r_budget);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = w_cfg_bad ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                // Abort outranks everything; a hit on the budget's last bit still reports as a hit.
                if (bus.abort) begin
                    w_next = S_DONE;
                end else if (bus.xin_valid && (w_hit_end || w_budget_end)) begin
                    w_next = S_DONE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy = (r_state == S_SCAN);
        bus.done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pat       <= '0;
            r_len       <= '0;
            r_overlap   <= 1'b0;
            r_target    <= '0;
            r_budget    <= '0;
            r_hist      <= '0;
            r_seen      <= '0;
            r_bit_cnt   <= '0;
            r_match_cnt <= '0;
            r_hit       <= 1'b0;
            r_timeout   <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_match     <= 1'b0;
        end else begin
            r_match <= 1'b0;
            if (r_state == S_IDLE && bus.start) begin
                r_pat       <= bus.cfg_pattern;
                r_len       <= bus.cfg_len;
                r_overlap   <= bus.cfg_overlap;
                r_target    <= bus.cfg_target;
                r_budget    <= bus.cfg_budget;
                r_hist      <= '0;
                r_seen      <= '0;
                r_bit_cnt   <= '0;
                r_match_cnt <= '0;
                r_hit       <= 1'b0;
                r_timeout   <= 1'b0;
                r_cfg_err   <= w_cfg_bad;
            end else if (w_accept) begin
                r_hist    <= w_shift[PAT_W-2:0];
                r_bit_cnt <= w_bit_inc;
                if (w_match) begin
                    r_match     <= 1'b1;
                    r_match_cnt <= w_cnt_inc;
                    // Without overlap the history stays, but the next match needs len fresh bits.
                    r_seen      <= r_overlap ? w_seen_sat : '0;
                end else begin
                    r_seen <= w_seen_sat;
                end
                if (w_hit_end) begin
                    r_hit <= 1'b1;
                end else if (w_budget_end) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign bus.match          = r_match;
    assign bus.match_cnt      = r_match_cnt;
    assign bus.result_hit     = r_hit;
    assign bus.result_timeout = r_timeout;
    assign bus.cfg_err        = r_cfg_err;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - directed plus randomized check of seq_scan_ctrl against a session model
module tb_seq_scan_ctrl;
    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 8;
    localparam int BUD_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seq_scan_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .BUD_W(BUD_W)) bus ();

    seq_scan_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .BUD_W(BUD_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Session model: 0 idle, 1 scanning, 2 ending
    int          m_phase;
    bit          m_bits[$];
    int          m_cut;
    int          m_cnt;
    bit          m_hit, m_to, m_err, m_match;
    logic [7:0]  m_pat;
    int          m_len, m_tgt, m_bud;
    bit          m_ovl;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {2'b00, bus.busy, bus.match, bus.done, bus.result_hit, bus.result_timeout,
                bus.cfg_err, bus.match_cnt};
    endfunction

    function automatic logic [15:0] model_vec();
        logic [7:0] c;
        c = m_cnt[7:0];
        return {2'b00, m_phase == 1, m_match, m_phase == 2, m_hit, m_to, m_err, c};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_hit = 0; m_to = 0; m_err = 0; m_match = 0; m_cut = 0;
        m_bits.delete();
    endtask

    task automatic model_step(input bit st, input bit xv, input bit x, input bit ab);
        int  total;
        bit  ok;
        m_match = 0;
        if (m_phase == 2) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (st) begin
                m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len); m_ovl = bus.cfg_overlap;
                m_tgt = int'(bus.cfg_target); m_bud = int'(bus.cfg_budget);
                m_bits.delete(); m_cut = 0; m_cnt = 0; m_hit = 0; m_to = 0;
                m_err = (m_len == 0) || (m_len > PAT_W) || (m_tgt == 0);
                m_phase = m_err ? 2 : 1;
            end
        end else begin
            if (ab) begin
                m_phase = 2;
            end else if (xv) begin
                m_bits.push_back(x);
                total = m_bits.size();
                ok = (total - m_cut) >= m_len;
                if (ok) begin
                    for (int j = 0; j < m_len; j++) begin
                        if (m_bits[total - 1 - j] != m_pat[j]) ok = 0;
                    end
                end
                if (ok) begin
                    m_cnt++;
                    m_match = 1;
                    if (!m_ovl) m_cut = total;
                end
                if (ok && m_cnt == m_tgt) begin
                    m_hit = 1; m_phase = 2;
                end else if (m_bud != 0 && total == m_bud) begin
                    m_to = 1; m_phase = 2;
                end
            end
        end
    endtask

    task automatic tick(input bit st, input bit xv, input bit x, input bit ab, input string tag);
        bus.start = st; bus.xin_valid = xv; bus.xin = x; bus.abort = ab;
        model_step(st, xv, x, ab);
        @(negedge clk);
        check(tag, dut_vec(), model_vec());
    endtask

    task automatic set_cfg(input logic [7:0] pat, input int len, input bit ovl,
                           input int tgt, input int bud);
        bus.cfg_pattern = pat;
        bus.cfg_len     = LEN_W'(len);
        bus.cfg_overlap = ovl;
        bus.cfg_target  = CNT_W'(tgt);
        bus.cfg_budget  = BUD_W'(bud);
    endtask

    task automatic send_bits(input logic [31:0] stream, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) tick(0, 1, stream[i], 0, tag);
    endtask

    function automatic int count_100(input logic [63:0] s, input int n);
        int c = 0;
        int fresh = 0;
        for (int i = n - 1; i >= 0; i--) begin
            fresh++;
            if (fresh >= 3 && s[i] == 0 && s[i+1] == 0 && s[i+2] == 1) begin
                c++;
                fresh = 0;
            end
        end
        return c;
    endfunction

    initial begin
        logic [63:0] gs;
        int          gn;
        int          k;
        bus.start = 0; bus.xin = 0; bus.xin_valid = 0; bus.abort = 0;
        set_cfg(8'h00, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_state", dut_vec(), 16'h0000);
        reset = 1'b1;
        tick(0, 0, 0, 0, "idle");

        // Overlapping 100, target 2, unlimited budget
        set_cfg(8'b100, 3, 1, 2, 0);
        tick(1, 0, 0, 0, "t1_start");
        send_bits(32'b1100100, 7, "t1_bits");
        check("t1_hit_cnt", {bus.done, bus.match, bus.result_hit, bus.result_timeout, 4'h0,
                             bus.match_cnt}, {4'b1110, 4'h0, 8'd2});
        tick(0, 0, 0, 0, "t1_idle");

        // 101 with budget 5, overlap on then off
        set_cfg(8'b101, 3, 1, 3, 5);
        tick(1, 0, 0, 0, "t2a_start");
        send_bits(32'b10101, 5, "t2a_bits");
        check("t2a_res", {bus.result_hit, bus.result_timeout, bus.match_cnt}, {2'b01, 8'd2});
        tick(0, 0, 0, 0, "t2a_idle");
        set_cfg(8'b101, 3, 0, 3, 5);
        tick(1, 0, 0, 0, "t2b_start");
        send_bits(32'b10101, 5, "t2b_bits");
        check("t2b_res", {bus.result_hit, bus.result_timeout, bus.match_cnt}, {2'b01, 8'd1});
        tick(0, 0, 0, 0, "t2b_idle");

        // Target and budget land on the same bit
        set_cfg(8'b100, 3, 1, 1, 3);
        tick(1, 0, 0, 0, "t3_start");
        send_bits(32'b100, 3, "t3_bits");
        check("t3_res", {bus.done, bus.result_hit, bus.result_timeout, bus.match_cnt},
              {3'b110, 8'd1});
        tick(0, 0, 0, 0, "t3_idle");

        // Illegal configurations, then a legal start clears the error
        set_cfg(8'b1, 0, 0, 1, 0);
        tick(1, 0, 0, 0, "t4_len0");
        check("t4_len0_err", {bus.busy, bus.done, bus.cfg_err}, 3'b011);
        tick(0, 0, 0, 0, "t4_idle");
        set_cfg(8'b1, 9, 0, 1, 0);
        tick(1, 0, 0, 0, "t4_len9");
        tick(0, 0, 0, 0, "t4_idle2");
        set_cfg(8'b1, 1, 0, 0, 0);
        tick(1, 0, 0, 0, "t4_tgt0");
        check("t4_tgt0_err", {bus.busy, bus.done, bus.cfg_err}, 3'b011);
        tick(0, 0, 0, 0, "t4_idle3");
        set_cfg(8'b101, 3, 1, 5, 0);
        tick(1, 0, 0, 0, "t5_start");
        check("t5_err_clr", {bus.busy, bus.cfg_err}, 2'b10);

        // Abort with a valid bit that would have completed a match
        send_bits(32'b1010, 4, "t5_bits");
        tick(0, 1, 1, 1, "t5_abort");
        check("t5_res", {bus.done, bus.match, bus.result_hit, bus.result_timeout, bus.match_cnt},
              {4'b1000, 8'd1});
        tick(1, 1, 1, 0, "t5_ignored");

        // Asynchronous reset mid-scan
        set_cfg(8'b100, 3, 1, 10, 0);
        tick(1, 0, 0, 0, "t6_start");
        send_bits(32'b1100, 4, "t6_bits");
        #2 reset = 1'b0;
        #1 check("t6_async", dut_vec(), 16'h0000);
        model_reset();
        @(negedge clk);
        tick(0, 1, 0, 0, "t6_held");
        reset = 1'b1;
        tick(0, 0, 0, 0, "t6_after");
        tick(0, 0, 0, 0, "t6_after2");

        // Same 100 stream with and without xin_valid gaps
        gs = {$urandom, $urandom};
        gn = 40;
        for (int pass = 0; pass < 2; pass++) begin
            set_cfg(8'b100, 3, 0, 255, 0);
            tick(1, 0, 0, 0, "t7_start");
            for (int i = gn - 1; i >= 0; i--) begin
                if (pass == 1) begin
                    while ($urandom_range(0, 2) == 0) tick(0, 0, ~gs[i], 0, "t7_gap");
                end
                tick(0, 1, gs[i], 0, "t7_bit");
            end
            check("t7_cnt", {8'h00, bus.match_cnt}, 16'(count_100(gs, gn)));
            tick(0, 0, 0, 1, "t7_abort");
            tick(0, 0, 0, 0, "t7_idle");
        end

        // Randomized sessions
        for (int s = 0; s < 40; s++) begin
            int len, tgt, bud;
            logic [7:0] pat;
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 8);
            tgt = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            bud = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 60);
            pat = 8'($urandom);
            set_cfg(pat, len, 1'($urandom), tgt, bud);
            tick(1, 0, 0, 0, "rnd_start");
            k = 0;
            for (int c = 0; c < 150 && m_phase == 1; c++) begin
                bit xv, x, ab;
                xv = $urandom_range(0, 9) < 7;
                ab = $urandom_range(0, 99) < 2;
                x = (len > 0 && len <= 8) ? pat[(len - 1) - (k % len)] : 1'b0;
                if ($urandom_range(0, 4) == 0) x = 1'($urandom);
                if (xv) k++;
                tick(1'($urandom), xv, x, ab, "rnd_step");
            end
            if (m_phase == 1) tick(0, 0, 0, 1, "rnd_abort");
            tick(0, 0, 0, 0, "rnd_end");
            tick(0, 0, 0, 0, "rnd_idle");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
